elem_serdiv: RTL
================

ELEM_SERDIV -- requirements
Module: elem_serdiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; equals $bits(elen_t).
REQ-002 SHALL have parameter STABLE_HANDSHAKE, default 1; 1 = in_rdy_o only in IDLE, 0 = also in DONE when out_rdy_i is high.
REQ-003 SHALL have port clk_i  input  1  clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port op_a_i  input  WIDTH  dividend.
REQ-006 SHALL have port op_b_i  input  WIDTH  divisor.
REQ-007 SHALL have port opcode_i  input  2  00 DIVU, 01 DIV, 10 REMU, 11 REM.
REQ-008 SHALL have port in_vld_i  input  1  operands valid.
REQ-009 SHALL have port in_rdy_o  output  1  operands accepted when high with in_vld_i.
REQ-010 SHALL have port flush_i  input  1  synchronous abort.
REQ-011 SHALL have port out_vld_o  output  1  res_o valid.
REQ-012 SHALL have port out_rdy_i  input  1  consumer accepts res_o.
REQ-013 SHALL have port res_o  output  WIDTH  quotient or remainder.

Function
REQ-014 SHALL implement FSM IDLE -> DIVIDE -> DONE; IDLE->DIVIDE on in_vld_i&&in_rdy_o; DIVIDE->DONE after WIDTH iterations; DONE->IDLE on out_rdy_i (or DONE->DIVIDE if STABLE_HANDSHAKE=0 and in_vld_i).
REQ-015 SHALL capture opcode, operand magnitudes (two's-complement abs for signed opcodes, raw for unsigned), and quotient/remainder sign flags only at the input handshake.
REQ-016 SHALL perform restoring division, one quotient bit per cycle, MSB first, iteration counter loaded with WIDTH-1, decrementing to 0.
REQ-017 SHALL assert out_vld_o exactly WIDTH+1 cycles after the accepting edge (33 for WIDTH=32), fixed, independent of operand values.
REQ-018 SHALL hold out_vld_o and res_o stable in DONE until out_rdy_i is sampled high.
REQ-019 SHALL negate quotient when signed op and sign(a)!=sign(b) and b!=0; negate remainder when signed op and a negative.
REQ-020 SHALL give divide-by-zero: quotient all ones, remainder = op_a_i, for signed and unsigned.
REQ-021 SHALL give signed overflow (most-negative / -1): quotient = most-negative, remainder 0.
REQ-022 SHALL drive in_rdy_o low in DIVIDE regardless of in_vld_i.
REQ-023 SHALL on flush_i high return to IDLE on the next edge from any state, out_vld_o low next cycle, result discarded; flush_i has priority over handshakes.
REQ-024 SHALL ignore in_vld_i in the flush cycle (no acceptance).

Reset
REQ-025 SHALL on rst_ni low go to IDLE asynchronously, clear counter, operand, quotient, remainder and flag registers to 0.
REQ-026 SHALL output after reset: out_vld_o 0, res_o 0, in_rdy_o 1.
REQ-027 SHALL abort any in-flight division on reset with no output produced after release.

Structure
REQ-028 SHALL take the 2-bit opcode enum (serdiv_op_e) and elen_t from synth_pkg; simd_div maps ara_op_e onto it.
REQ-029 SHALL be a single module, no sub-modules; FSM, counter and subtract/shift datapath inline.

Verification
REQ-030 SHALL test DIVU 100/7 -> res_o 14, out_vld_o at cycle 33 after handshake; REMU 100/7 -> 2.
REQ-031 SHALL test DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
REQ-032 SHALL test divide-by-zero: DIVU 5/0 -> 0xFFFFFFFF; DIV -5/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-033 SHALL test overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-034 SHALL test out_rdy_i low 5 cycles in DONE -> res_o stable, in_rdy_o low (STABLE_HANDSHAKE=1); STABLE_HANDSHAKE=0 back-to-back ops -> second accepted in DONE cycle.
REQ-035 SHALL test flush_i at DIVIDE cycle 10 and rst_ni low at cycle 10 -> IDLE, in_rdy_o 1 next cycle, no out_vld_o pulse.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: shared element width and serial-divider opcode/state types
package synth_pkg;
   typedef logic [31:0] elen_t;
   typedef enum logic [1:0] {OP_DIVU = 2'b00, OP_DIV = 2'b01, OP_REMU = 2'b10, OP_REM = 2'b11} serdiv_op_e;
   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} serdiv_state_e;
endpackage

// File: rtl/elem_serdiv.sv
// elem_serdiv: serial restoring divider, one quotient bit per cycle, signed/unsigned div and rem
// Ports: clk_i/rst_ni clock and async active-low reset; op_a_i/op_b_i dividend/divisor;
// opcode_i 00 DIVU 01 DIV 10 REMU 11 REM; in_vld_i/in_rdy_o operand handshake; flush_i abort;
// out_vld_o/out_rdy_i result handshake; res_o quotient or remainder.
module elem_serdiv
   import synth_pkg::*;
#(
   parameter int unsigned WIDTH            = 32,
   parameter bit          STABLE_HANDSHAKE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic [1:0]       opcode_i,
   input  logic             in_vld_i,
   output logic             in_rdy_o,
   input  logic             flush_i,
   output logic             out_vld_o,
   input  logic             out_rdy_i,
   output logic [WIDTH-1:0] res_o
);
   localparam int unsigned CW = $clog2(WIDTH);
   serdiv_state_e    state_q;
   serdiv_op_e       op_q, op_in;
   logic [WIDTH-1:0] quo_q, rem_q, b_q, res_q, a_mag, b_mag, q_fix, r_fix, diff;
   logic [CW-1:0]    cnt_q;
   logic             qneg_q, rneg_q, fin_q, out_vld_q;
   logic             accept, sgn, a_neg, b_neg, fit;
   logic [WIDTH:0]   trial, diff_full;
   assign op_in     = serdiv_op_e'(opcode_i);
   assign sgn       = (op_in == OP_DIV) || (op_in == OP_REM);
   assign a_neg     = sgn && op_a_i[WIDTH-1];
   assign b_neg     = sgn && op_b_i[WIDTH-1];
   assign a_mag     = a_neg ? -op_a_i : op_a_i;
   assign b_mag     = b_neg ? -op_b_i : op_b_i;
   // a flush cycle never accepts operands
   assign in_rdy_o  = !flush_i && (state_q == IDLE || (!STABLE_HANDSHAKE && state_q == DONE && out_rdy_i));
   assign accept    = in_vld_i && in_rdy_o;
   // quo_q holds the remaining dividend bits at the top and shifts in quotient bits at the bottom
   assign trial     = {rem_q, quo_q[WIDTH-1]};
   assign diff_full = trial - {1'b0, b_q};
   assign diff      = diff_full[WIDTH-1:0];
   assign fit       = trial >= {1'b0, b_q};
   assign q_fix     = qneg_q ? -quo_q : quo_q;
   assign r_fix     = rneg_q ? -rem_q : rem_q;
   assign out_vld_o = out_vld_q;
   assign res_o     = res_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         op_q      <= OP_DIVU;
         quo_q     <= '0;
         rem_q     <= '0;
         b_q       <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         fin_q     <= 1'b0;
         out_vld_q <= 1'b0;
      end else if (flush_i) begin
         state_q   <= IDLE;
         fin_q     <= 1'b0;
         out_vld_q <= 1'b0;
      end else if (accept) begin
         state_q   <= DIVIDE;
         op_q      <= op_in;
         quo_q     <= a_mag;
         rem_q     <= '0;
         b_q       <= b_mag;
         cnt_q     <= CW'(WIDTH - 1);
         qneg_q    <= sgn && (op_a_i[WIDTH-1] != op_b_i[WIDTH-1]) && (op_b_i != '0);
         rneg_q    <= a_neg;
         fin_q     <= 1'b0;
         out_vld_q <= 1'b0;
      end else begin
         case (state_q)
            DIVIDE: begin
               // one extra cycle after the last bit applies the sign fix-up into res_q
               if (fin_q) begin
                  state_q   <= DONE;
                  fin_q     <= 1'b0;
                  out_vld_q <= 1'b1;
                  res_q     <= (op_q == OP_REMU || op_q == OP_REM) ? r_fix : q_fix;
               end else begin
                  rem_q <= fit ? diff : trial[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], fit};
                  cnt_q <= cnt_q - 1'b1;
                  fin_q <= (cnt_q == '0);
               end
            end
            DONE: begin
               if (out_rdy_i) begin
                  state_q   <= IDLE;
                  out_vld_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
